apb_master_arbiter: RTL

Sequencing APB master that shares the single APB bus between two independent requesters (requester 0 and requester 1). It arbitrates round-robin and runs the SETUP/ACCESS phases itself. It decodes the per-request target code onto the GPIO (PSEL1) and UART (PSEL2) select lines and returns read data, completion and error status to the winning requester. It sits between the system-level command sources and the GPIO/UART slaves, and replaces test-bench-driven psel/penable/transfer sequencing.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_rr_arbiter.sv | 22 ++
 rtl/apb_master_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared constants and types for the two-requester APB master.
package apb_pkg;

  localparam int unsigned TGT_W       = 2;
  localparam int unsigned WAIT_W      = 8;
  localparam int unsigned TIMEOUT_DEF = 16;

  localparam logic [TGT_W-1:0] TGT_IDLE = 2'd0;
  localparam logic [TGT_W-1:0] TGT_GPIO = 2'd1;
  localparam logic [TGT_W-1:0] TGT_UART = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DECERR = 2'd3
  } state_e;

  function automatic logic tgt_valid(input logic [TGT_W-1:0] tgt);
    return (tgt == TGT_GPIO) || (tgt == TGT_UART);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter; prio names the port favoured on the next tie.
module apb_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant_c,
  output logic       prio
);

  always_comb begin
    grant_c = req;
    if (req == 2'b11) grant_c = prio ? 2'b10 : 2'b01;
  end

  // After a grant the other port becomes favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   prio <= 1'b0;
    else if (advance && |grant_c) prio <= grant_c[0];
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin grant, SETUP/ACCESS
// sequencing, GPIO/UART decode, timeout and per-port response registers.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [1:0]        tgt0,
  input  logic [1:0]        tgt1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY1,
  input  logic              PREADY2,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2
);

  localparam int unsigned CNT_W = WAIT_W + 1;

  state_e             state, state_nx;
  logic [1:0]         req_m, gnt_c;
  logic               prio, owner, advance;
  logic [TGT_W-1:0]   tgt_q, tgt_gnt, tgt_nx;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               sel_ready, timeout_hit;
  logic [DATA_W-1:0]  sel_rdata;
  logic               done_ok, done_err;
  logic               psel1_nx, psel2_nx, penable_nx, ack0_nx, ack1_nx;

  // A port whose ack is high this cycle is masked so it cannot be regranted.
  assign req_m   = {req1 & ~ack1, req0 & ~ack0};
  assign advance = (state == ST_IDLE) && (|req_m);
  assign owner   = ~prio;
  assign tgt_gnt = gnt_c[1] ? tgt1 : tgt0;

  assign sel_ready   = (tgt_q == TGT_GPIO) ? PREADY1 : PREADY2;
  assign sel_rdata   = (tgt_q == TGT_GPIO) ? PRDATA1 : PRDATA2;
  assign timeout_hit = (CNT_W'(wait_cnt) + CNT_W'(1)) >= CNT_W'(TIMEOUT);

  apb_rr_arbiter u_arb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (req_m),
    .advance (advance),
    .grant_c (gnt_c),
    .prio    (prio)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (advance) state_nx = tgt_valid(tgt_gnt) ? ST_SETUP : ST_DECERR;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: if (sel_ready || timeout_hit) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Next values of the registered bus and response outputs.
  always_comb begin
    done_ok    = 1'b0;
    done_err   = 1'b0;
    tgt_nx     = advance ? tgt_gnt : tgt_q;
    if (state == ST_ACCESS) begin
      done_ok  = sel_ready;
      done_err = !sel_ready && timeout_hit;
    end
    if (state == ST_DECERR) done_err = 1'b1;
    penable_nx = (state_nx == ST_ACCESS);
    psel1_nx   = (state_nx == ST_SETUP || state_nx == ST_ACCESS) && (tgt_nx == TGT_GPIO);
    psel2_nx   = (state_nx == ST_SETUP || state_nx == ST_ACCESS) && (tgt_nx == TGT_UART);
    ack0_nx    = (done_ok || done_err) && !owner;
    ack1_nx    = (done_ok || done_err) && owner;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL1   <= 1'b0;
      PSEL2   <= 1'b0;
      PENABLE <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      PSEL1   <= psel1_nx;
      PSEL2   <= psel2_nx;
      PENABLE <= penable_nx;
      ack0    <= ack0_nx;
      ack1    <= ack1_nx;
      err0    <= ack0_nx && done_err;
      err1    <= ack1_nx && done_err;
      if (ack0_nx) rdata0 <= done_err ? '0 : (PWRITE ? rdata0 : sel_rdata);
      if (ack1_nx) rdata1 <= done_err ? '0 : (PWRITE ? rdata1 : sel_rdata);
    end
  end

  // Request field latches and the saturating ACCESS wait counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tgt_q    <= TGT_IDLE;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      wait_cnt <= '0;
    end else begin
      if (advance) begin
        tgt_q  <= tgt_gnt;
        PWRITE <= gnt_c[1] ? wr1 : wr0;
        PADDR  <= gnt_c[1] ? addr1 : addr0;
        PWDATA <= gnt_c[1] ? wdata1 : wdata0;
      end
      if (state_nx == ST_SETUP)
        wait_cnt <= '0;
      else if (state == ST_ACCESS && !sel_ready && wait_cnt != '1)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule
